rmst_tile_load_ctrl: RTL and testbench

- Sequences a multi-tile input load through the read-master-to-RAM tile loader.
- Per tile: drives the loader's configuration (raddr, iolen, config_done), pulses load_data_start, waits for load_data_done, then advances the address by a stride.
- Manages a two-bank ping-pong on-chip buffer. Loads stall while the target bank is still held by the downstream compute consumer, which releases banks with a handshake.

---
 rtl/rmst_tile_load_ctrl_if.sv | 39 +++
 rtl/rmst_tile_load_ctrl.sv | 189 ++++++++++++++++++
 tb/tb_rmst_tile_load_ctrl.sv | 392 +++++++++++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/rmst_tile_load_ctrl_if.sv
// rtl/rmst_tile_load_ctrl_if.sv - job, loader and consumer signals of the tile load controller
// slave is the controller side; master is the job issuer / loader / consumer side.
interface rmst_tile_load_ctrl_if #(
    parameter int AW  = 12,
    parameter int XAW = 32,
    parameter int NW  = 16
);
    logic           start;
    logic [XAW-1:0] cfg_base;
    logic [AW-1:0]  cfg_tile_len;
    logic [XAW-1:0] cfg_tile_stride;
    logic [NW-1:0]  cfg_tile_num;
    logic           busy;
    logic           done;
    logic           ld_config_done;
    logic [XAW-1:0] ld_param_raddr;
    logic [AW-1:0]  ld_param_iolen;
    logic           ld_load_start;
    logic           ld_load_done;
    logic           ld_bank_sel;
    logic           tile_valid;
    logic           tile_bank;
    logic [NW-1:0]  tile_idx;
    logic           tile_release;

    modport slave (
        input  start, cfg_base, cfg_tile_len, cfg_tile_stride, cfg_tile_num,
        input  ld_load_done, tile_release,
        output busy, done, ld_config_done, ld_param_raddr, ld_param_iolen,
        output ld_load_start, ld_bank_sel, tile_valid, tile_bank, tile_idx
    );

    modport master (
        output start, cfg_base, cfg_tile_len, cfg_tile_stride, cfg_tile_num,
        output ld_load_done, tile_release,
        input  busy, done, ld_config_done, ld_param_raddr, ld_param_iolen,
        input  ld_load_start, ld_bank_sel, tile_valid, tile_bank, tile_idx
    );
endinterface

// File: rtl/rmst_tile_load_ctrl.sv
// rtl/rmst_tile_load_ctrl.sv - multi-tile load sequencer with ping-pong bank handoff
// Every output is a flop loaded from the next-state values, so presentation tracks state exactly.
module rmst_tile_load_ctrl #(
    parameter int AW  = 12,
    parameter int XAW = 32,
    parameter int NW  = 16
) (
    input  logic                 clk,
    input  logic                 rst,
    rmst_tile_load_ctrl_if.slave bus
);
    typedef enum logic [2:0] {
        S_IDLE,
        S_CFG,
        S_START,
        S_WAIT,
        S_HOLD,
        S_FIN
    } state_t;

    state_t         state_q, state_d;
    logic [1:0]     full_q, full_d;
    logic           wb_q, wb_d;
    logic           rb_q, rb_d;
    logic [NW-1:0]  loaded_q, loaded_d;
    logic [NW-1:0]  rel_q, rel_d;
    logic [XAW-1:0] addr_q, addr_d;
    logic [AW-1:0]  len_q, len_d;
    logic [XAW-1:0] stride_q, stride_d;
    logic [NW-1:0]  num_q, num_d;
    logic           ld_done_prev_q;
    logic           load_rise;

    logic           busy_q, busy_d;
    logic           done_q, done_d;
    logic           cfg_done_q, cfg_done_d;
    logic [XAW-1:0] raddr_q, raddr_d;
    logic [AW-1:0]  iolen_q, iolen_d;
    logic           load_start_q, load_start_d;
    logic           bank_sel_q, bank_sel_d;
    logic           tile_valid_q, tile_valid_d;
    logic           tile_bank_q, tile_bank_d;
    logic [NW-1:0]  tile_idx_q, tile_idx_d;

    always_comb begin
        state_d   = state_q;
        full_d    = full_q;
        wb_d      = wb_q;
        rb_d      = rb_q;
        loaded_d  = loaded_q;
        rel_d     = rel_q;
        addr_d    = addr_q;
        len_d     = len_q;
        stride_d  = stride_q;
        num_d     = num_q;
        busy_d    = busy_q;
        done_d    = 1'b0;
        raddr_d   = raddr_q;
        iolen_d   = iolen_q;
        load_rise = bus.ld_load_done & ~ld_done_prev_q;

        // Consumer release is applied first; a same-cycle load completion always targets the other flag.
        if (bus.tile_release && tile_valid_q) begin
            full_d[rb_q] = 1'b0;
            rb_d         = ~rb_q;
            rel_d        = rel_q + 1'b1;
        end

        case (state_q)
            S_IDLE: begin
                if (bus.start) begin
                    addr_d   = bus.cfg_base;
                    len_d    = bus.cfg_tile_len;
                    stride_d = bus.cfg_tile_stride;
                    num_d    = bus.cfg_tile_num;
                    if (bus.cfg_tile_num == '0) begin
                        done_d = 1'b1;
                    end else begin
                        state_d  = S_CFG;
                        busy_d   = 1'b1;
                        loaded_d = '0;
                        rel_d    = '0;
                    end
                end
            end
            S_CFG:   state_d = S_START;
            S_START: state_d = S_WAIT;
            S_WAIT: begin
                if (load_rise) begin
                    full_d[wb_q] = 1'b1;
                    wb_d         = ~wb_q;
                    loaded_d     = loaded_q + 1'b1;
                    addr_d       = addr_q + stride_q;
                    if (loaded_d == num_q) begin
                        state_d = S_FIN;
                    end else if (full_d[wb_d]) begin
                        state_d = S_HOLD;
                    end else begin
                        state_d = S_CFG;
                    end
                end
            end
            S_HOLD: begin
                if (!full_q[wb_q]) begin
                    state_d = S_CFG;
                end
            end
            S_FIN: begin
                if (full_q == 2'b00) begin
                    done_d  = 1'b1;
                    busy_d  = 1'b0;
                    state_d = S_IDLE;
                end
            end
            default: state_d = S_IDLE;
        endcase

        // Loader parameters only change on entry to CFG and stay put while the loader runs.
        if (state_d == S_CFG) begin
            raddr_d = addr_d;
            iolen_d = len_d;
        end
        cfg_done_d   = (state_d == S_CFG);
        load_start_d = (state_d == S_START);
        bank_sel_d   = wb_d;
        tile_valid_d = full_d[rb_d];
        tile_bank_d  = rb_d;
        tile_idx_d   = rel_d;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q        <= S_IDLE;
            full_q         <= 2'b00;
            wb_q           <= 1'b0;
            rb_q           <= 1'b0;
            loaded_q       <= '0;
            rel_q          <= '0;
            addr_q         <= '0;
            len_q          <= '0;
            stride_q       <= '0;
            num_q          <= '0;
            ld_done_prev_q <= 1'b0;
            busy_q         <= 1'b0;
            done_q         <= 1'b0;
            cfg_done_q     <= 1'b0;
            raddr_q        <= '0;
            iolen_q        <= '0;
            load_start_q   <= 1'b0;
            bank_sel_q     <= 1'b0;
            tile_valid_q   <= 1'b0;
            tile_bank_q    <= 1'b0;
            tile_idx_q     <= '0;
        end else begin
            state_q        <= state_d;
            full_q         <= full_d;
            wb_q           <= wb_d;
            rb_q           <= rb_d;
            loaded_q       <= loaded_d;
            rel_q          <= rel_d;
            addr_q         <= addr_d;
            len_q          <= len_d;
            stride_q       <= stride_d;
            num_q          <= num_d;
            ld_done_prev_q <= bus.ld_load_done;
            busy_q         <= busy_d;
            done_q         <= done_d;
            cfg_done_q     <= cfg_done_d;
            raddr_q        <= raddr_d;
            iolen_q        <= iolen_d;
            load_start_q   <= load_start_d;
            bank_sel_q     <= bank_sel_d;
            tile_valid_q   <= tile_valid_d;
            tile_bank_q    <= tile_bank_d;
            tile_idx_q     <= tile_idx_d;
        end
    end

    assign bus.busy           = busy_q;
    assign bus.done           = done_q;
    assign bus.ld_config_done = cfg_done_q;
    assign bus.ld_param_raddr = raddr_q;
    assign bus.ld_param_iolen = iolen_q;
    assign bus.ld_load_start  = load_start_q;
    assign bus.ld_bank_sel    = bank_sel_q;
    assign bus.tile_valid     = tile_valid_q;
    assign bus.tile_bank      = tile_bank_q;
    assign bus.tile_idx       = tile_idx_q;
endmodule

// File: tb/tb_rmst_tile_load_ctrl.sv
// tb/tb_rmst_tile_load_ctrl.sv - directed self-checking bench for rmst_tile_load_ctrl
module tb_rmst_tile_load_ctrl;
    localparam int AW  = 12;
    localparam int XAW = 32;
    localparam int NW  = 16;

    logic clk = 1'b0;
    logic rst;
    int   cyc = 0;
    int   n_vec = 0;
    int   n_err = 0;

    rmst_tile_load_ctrl_if #(.AW(AW), .XAW(XAW), .NW(NW)) bus ();

    rmst_tile_load_ctrl #(.AW(AW), .XAW(XAW), .NW(NW)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus.slave)
    );

    initial forever #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    // Event recorder, sampled on the falling edge; cleared while rst is high.
    logic [XAW-1:0] m_cfg_addr[$];
    int m_cfg_bank[$], m_cfg_len[$], m_cfg_cyc[$], m_ls_cyc[$];
    int m_rel_idx[$], m_rel_bank[$], m_rel_cyc[$];
    int m_done_cyc[$], m_done_busy[$], m_done_bprev[$];
    int busy_seen, busy_prev;

    always @(negedge clk) begin
        if (rst) begin
            m_cfg_addr.delete(); m_cfg_bank.delete(); m_cfg_len.delete(); m_cfg_cyc.delete();
            m_ls_cyc.delete(); m_rel_idx.delete(); m_rel_bank.delete(); m_rel_cyc.delete();
            m_done_cyc.delete(); m_done_busy.delete(); m_done_bprev.delete();
            busy_seen = 0;
            busy_prev = 0;
        end else begin
            if (bus.ld_config_done) begin
                m_cfg_addr.push_back(bus.ld_param_raddr);
                m_cfg_bank.push_back(int'(bus.ld_bank_sel));
                m_cfg_len.push_back(int'(bus.ld_param_iolen));
                m_cfg_cyc.push_back(cyc);
            end
            if (bus.ld_load_start) m_ls_cyc.push_back(cyc);
            if (bus.tile_release && bus.tile_valid) begin
                m_rel_idx.push_back(int'(bus.tile_idx));
                m_rel_bank.push_back(int'(bus.tile_bank));
                m_rel_cyc.push_back(cyc);
            end
            if (bus.done) begin
                m_done_cyc.push_back(cyc);
                m_done_busy.push_back(int'(bus.busy));
                m_done_bprev.push_back(busy_prev);
            end
            if (bus.busy) busy_seen++;
            busy_prev = int'(bus.busy);
        end
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        rst = 1'b1;
        bus.start = 1'b0;
        bus.ld_load_done = 1'b0;
        bus.tile_release = 1'b0;
        step();
        step();
        rst = 1'b0;
        step();
    endtask

    task automatic start_job(input logic [XAW-1:0] base, input logic [AW-1:0] len,
                             input logic [XAW-1:0] stride, input logic [NW-1:0] num, output int t);
        bus.cfg_base = base;
        bus.cfg_tile_len = len;
        bus.cfg_tile_stride = stride;
        bus.cfg_tile_num = num;
        bus.start = 1'b1;
        t = cyc;
        step();
        bus.start = 1'b0;
    endtask

    task automatic wait_ls(input int n, input string tag);
        bit ok = 0;
        for (int i = 0; i < 60; i++) begin
            if (m_ls_cyc.size() >= n) begin ok = 1; break; end
            step();
        end
        n_vec++;
        if (!ok) begin n_err++; $display("FAIL %s: load_start count %0d, required %0d", tag, m_ls_cyc.size(), n); end
    endtask

    task automatic wait_valid(input string tag);
        bit ok = 0;
        for (int i = 0; i < 60; i++) begin
            if (bus.tile_valid) begin ok = 1; break; end
            step();
        end
        n_vec++;
        if (!ok) begin n_err++; $display("FAIL %s: tile_valid got 0, required 1", tag); end
    endtask

    task automatic wait_done(input string tag);
        bit ok = 0;
        for (int i = 0; i < 40; i++) begin
            if (m_done_cyc.size() >= 1) begin ok = 1; break; end
            step();
        end
        n_vec++;
        if (!ok) begin n_err++; $display("FAIL %s: no done pulse within bound", tag); end
    endtask

    task automatic pulse_done(input int hold);
        bus.ld_load_done = 1'b1;
        repeat (hold) step();
        bus.ld_load_done = 1'b0;
    endtask

    task automatic release_one();
        bus.tile_release = 1'b1;
        step();
        bus.tile_release = 1'b0;
    endtask

    task automatic test_reset();
        rst = 1'b1;
        bus.start = 1'b0;
        bus.cfg_base = '0;
        bus.cfg_tile_len = '0;
        bus.cfg_tile_stride = '0;
        bus.cfg_tile_num = '0;
        bus.ld_load_done = 1'b0;
        bus.tile_release = 1'b0;
        step();
        step();
        n_vec++;
        if ({bus.busy, bus.done, bus.ld_config_done, bus.ld_load_start, bus.ld_bank_sel,
             bus.tile_valid, bus.tile_bank} !== 7'b0) begin
            n_err++; $display("FAIL reset_flags: got %b, required 0", {bus.busy, bus.done,
                bus.ld_config_done, bus.ld_load_start, bus.ld_bank_sel, bus.tile_valid, bus.tile_bank});
        end
        n_vec++;
        if ({bus.ld_param_raddr, bus.ld_param_iolen, bus.tile_idx} !== '0) begin
            n_err++; $display("FAIL reset_values: raddr %h iolen %h idx %h, required 0",
                bus.ld_param_raddr, bus.ld_param_iolen, bus.tile_idx);
        end
        rst = 1'b0;
        repeat (4) step();
        n_vec++;
        if (busy_seen !== 0 || m_cfg_addr.size() !== 0) begin
            n_err++; $display("FAIL reset_idle: busy_seen %0d cfg %0d, required 0", busy_seen, m_cfg_addr.size());
        end
    endtask

    task automatic test_normal();
        int t0;
        logic [XAW-1:0] exp_addr[3] = '{32'h1000, 32'h1040, 32'h1080};
        int exp_bank[3] = '{0, 1, 0};
        do_reset();
        start_job(32'h1000, 12'd8, 32'h40, 16'd3, t0);
        for (int i = 0; i < 3; i++) begin
            wait_ls(i + 1, "normal_ls");
            step();
            pulse_done(1);
            wait_valid("normal_valid");
            step();
            release_one();
        end
        wait_done("normal_done");
        repeat (4) step();
        for (int i = 0; i < 3; i++) begin
            n_vec++;
            if (i >= m_cfg_addr.size() || m_cfg_addr[i] !== exp_addr[i] || m_cfg_bank[i] !== exp_bank[i]
                || m_cfg_len[i] !== 8) begin
                n_err++; $display("FAIL normal_cfg%0d: entries %0d, required raddr %h bank %0d len 8",
                    i, m_cfg_addr.size(), exp_addr[i], exp_bank[i]);
            end
            n_vec++;
            if (i >= m_rel_idx.size() || m_rel_idx[i] !== i || m_rel_bank[i] !== exp_bank[i]) begin
                n_err++; $display("FAIL normal_tile%0d: entries %0d, required idx %0d bank %0d",
                    i, m_rel_idx.size(), i, exp_bank[i]);
            end
        end
        n_vec++;
        if (m_cfg_cyc.size() < 1 || m_ls_cyc.size() < 1 || m_cfg_cyc[0] !== t0 + 1 || m_ls_cyc[0] !== t0 + 2) begin
            n_err++; $display("FAIL start_timing: cfg/ls entries %0d/%0d, required cycles %0d/%0d",
                m_cfg_cyc.size(), m_ls_cyc.size(), t0 + 1, t0 + 2);
        end
        n_vec++;
        if (m_done_cyc.size() !== 1 || m_done_busy[0] !== 0 || m_done_bprev[0] !== 1
            || m_rel_cyc.size() !== 3 || m_done_cyc[0] <= m_rel_cyc[2]) begin
            n_err++; $display("FAIL normal_finish: done pulses %0d releases %0d, required 1 pulse after 3rd release with busy falling",
                m_done_cyc.size(), m_rel_cyc.size());
        end
    endtask

    task automatic test_backpressure();
        int t0, n;
        bit ok = 0;
        do_reset();
        start_job(32'h2000, 12'd4, 32'h100, 16'd4, t0);
        wait_ls(1, "bp_ls1");
        step();
        pulse_done(1);
        wait_ls(2, "bp_ls2");
        step();
        pulse_done(1);
        repeat (6) step();
        n_vec++;
        if (m_cfg_addr.size() !== 2 || m_ls_cyc.size() !== 2) begin
            n_err++; $display("FAIL bp_stall: cfg %0d ls %0d, required 2/2", m_cfg_addr.size(), m_ls_cyc.size());
        end
        n_vec++;
        if (bus.tile_valid !== 1'b1 || bus.tile_bank !== 1'b0 || bus.busy !== 1'b1) begin
            n_err++; $display("FAIL bp_present: valid %b bank %b busy %b, required 1 0 1",
                bus.tile_valid, bus.tile_bank, bus.busy);
        end
        n = cyc;
        release_one();
        for (int i = 0; i < 20; i++) begin
            if (m_cfg_addr.size() >= 3) begin ok = 1; break; end
            step();
        end
        n_vec++;
        if (!ok || m_cfg_cyc[2] !== n + 2 || m_cfg_addr[2] !== 32'h2200) begin
            n_err++; $display("FAIL bp_resume: cfg entries %0d, required 3rd config at cycle %0d raddr 00002200", m_cfg_addr.size(), n + 2);
        end
    endtask

    task automatic test_zero();
        int t0;
        do_reset();
        start_job(32'h5000, 12'd4, 32'h10, 16'd0, t0);
        n_vec++;
        if (bus.done !== 1'b1 || bus.busy !== 1'b0) begin
            n_err++; $display("FAIL zero_done: done %b busy %b, required 1 0", bus.done, bus.busy);
        end
        step();
        n_vec++;
        if (bus.done !== 1'b0) begin n_err++; $display("FAIL zero_pulse: done %b, required 0", bus.done); end
        repeat (5) step();
        n_vec++;
        if (m_cfg_addr.size() !== 0 || m_ls_cyc.size() !== 0 || busy_seen !== 0 || m_done_cyc.size() !== 1) begin
            n_err++; $display("FAIL zero_quiet: cfg %0d ls %0d busy %0d done %0d, required 0 0 0 1",
                m_cfg_addr.size(), m_ls_cyc.size(), busy_seen, m_done_cyc.size());
        end
    endtask

    task automatic test_edges();
        int t0;
        do_reset();
        start_job(32'h3000, 12'd4, 32'h20, 16'd2, t0);
        wait_ls(1, "edge_ls");
        step();
        bus.ld_load_done = 1'b1;
        step();
        step();
        bus.cfg_base = 32'h9000;
        bus.cfg_tile_num = 16'd7;
        bus.start = 1'b1;
        step();
        bus.start = 1'b0;
        step();
        step();
        bus.ld_load_done = 1'b0;
        repeat (4) step();
        n_vec++;
        if (m_cfg_addr.size() !== 2 || m_cfg_addr[1] !== 32'h3020 || m_ls_cyc.size() !== 2) begin
            n_err++; $display("FAIL edge_level: cfg %0d ls %0d, required 2 configs (2nd raddr 00003020)",
                m_cfg_addr.size(), m_ls_cyc.size());
        end
        release_one();
        n_vec++;
        if (bus.tile_valid !== 1'b0 || bus.tile_idx !== 16'd1) begin
            n_err++; $display("FAIL edge_single: valid %b idx %0d, required 0 1", bus.tile_valid, bus.tile_idx);
        end
        step();
        pulse_done(1);
        wait_valid("edge_valid2");
        release_one();
        wait_done("edge_done");
        n_vec++;
        if (m_cfg_addr.size() !== 2 || m_done_cyc.size() !== 1) begin
            n_err++; $display("FAIL edge_busy_start: cfg %0d done %0d, required 2 1", m_cfg_addr.size(), m_done_cyc.size());
        end
    endtask

    task automatic test_simul_wrap();
        int t0, c;
        logic [XAW-1:0] exp_addr[4] = '{32'hFFFF_FFC0, 32'h0000_0000, 32'h0000_0040, 32'h0000_0080};
        do_reset();
        start_job(32'hFFFF_FFC0, 12'd2, 32'h40, 16'd4, t0);
        wait_ls(1, "sim_ls1");
        step();
        pulse_done(1);
        release_one();
        wait_ls(2, "sim_ls2");
        step();
        pulse_done(1);
        wait_ls(3, "sim_ls3");
        step();
        n_vec++;
        if (bus.tile_valid !== 1'b1 || bus.tile_bank !== 1'b1) begin
            n_err++; $display("FAIL sim_pre: valid %b bank %b, required 1 1", bus.tile_valid, bus.tile_bank);
        end
        bus.ld_load_done = 1'b1;
        bus.tile_release = 1'b1;
        c = cyc;
        step();
        bus.ld_load_done = 1'b0;
        bus.tile_release = 1'b0;
        n_vec++;
        if (bus.ld_config_done !== 1'b1 || bus.tile_valid !== 1'b1 || bus.tile_bank !== 1'b0
            || bus.tile_idx !== 16'd2 || bus.ld_bank_sel !== 1'b1) begin
            n_err++; $display("FAIL sim_both: cfg %b valid %b bank %b idx %0d wb %b at cycle %0d, required 1 1 0 2 1",
                bus.ld_config_done, bus.tile_valid, bus.tile_bank, bus.tile_idx, bus.ld_bank_sel, c + 1);
        end
        step();
        for (int i = 0; i < 4; i++) begin
            n_vec++;
            if (i >= m_cfg_addr.size() || m_cfg_addr[i] !== exp_addr[i]) begin
                n_err++; $display("FAIL wrap_addr%0d: entries %0d, required raddr %h", i, m_cfg_addr.size(), exp_addr[i]);
            end
        end
    endtask

    task automatic test_reset_mid();
        int t0;
        do_reset();
        start_job(32'h4000, 12'd8, 32'h80, 16'd3, t0);
        wait_ls(1, "rm_ls1");
        step();
        pulse_done(1);
        wait_ls(2, "rm_ls2");
        step();
        n_vec++;
        if (bus.tile_valid !== 1'b1 || bus.busy !== 1'b1 || bus.ld_bank_sel !== 1'b1) begin
            n_err++; $display("FAIL rm_pre: valid %b busy %b wb %b, required 1 1 1", bus.tile_valid, bus.busy, bus.ld_bank_sel);
        end
        #2;
        rst = 1'b1;
        #1;
        n_vec++;
        if ({bus.busy, bus.done, bus.ld_config_done, bus.ld_load_start, bus.ld_bank_sel,
             bus.tile_valid, bus.tile_bank} !== 7'b0 || bus.ld_param_raddr !== '0
            || bus.ld_param_iolen !== '0 || bus.tile_idx !== '0) begin
            n_err++; $display("FAIL rm_async: busy %b valid %b wb %b raddr %h iolen %h, required all 0",
                bus.busy, bus.tile_valid, bus.ld_bank_sel, bus.ld_param_raddr, bus.ld_param_iolen);
        end
        step();
        rst = 1'b0;
        step();
        start_job(32'h7000, 12'd8, 32'h80, 16'd2, t0);
        n_vec++;
        if (bus.ld_config_done !== 1'b1 || bus.ld_param_raddr !== 32'h7000) begin
            n_err++; $display("FAIL rm_restart: cfg %b raddr %h, required 1 00007000", bus.ld_config_done, bus.ld_param_raddr);
        end
        wait_ls(1, "rm_ls3");
        step();
        pulse_done(1);
        wait_valid("rm_valid");
        n_vec++;
        if (bus.tile_idx !== 16'd0 || bus.tile_bank !== 1'b0) begin
            n_err++; $display("FAIL rm_tile: idx %0d bank %b, required 0 0", bus.tile_idx, bus.tile_bank);
        end
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        test_reset();
        test_normal();
        test_backpressure();
        test_zero();
        test_edges();
        test_simul_wrap();
        test_reset_mid();
        do_reset();
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end
endmodule
